// File: rtl/mem_dcache_pkg.sv
// mem_dcache_pkg: shared definitions for the MEM-stage data cache.
//   - state_t        : controller states (idle / write-back / fill)
//   - DEFAULT_LINES  : default number of cache lines
//   - DEFAULT_WORDS  : default 32-bit words per line
//   - MEM_WB_BUBBLE  : value presented on the load-data path while the
//                      MEM_WB register must latch a bubble
//   - off_bits/idx_bits/tag_bits : address field widths from LINES/WORDS
//   - sat_inc        : saturating 32-bit increment used by the counters
package mem_dcache_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WB   = 2'd1,
        ST_FILL = 2'd2
    } state_t;

    localparam int DEFAULT_LINES = 64;
    localparam int DEFAULT_WORDS = 4;

    // MEM_WB latches zero while the pipeline is stalled on a miss.
    localparam logic [31:0] MEM_WB_BUBBLE = 32'h0000_0000;

    // Word-offset bits inside a line (byte bits [1:0] are not counted).
    function automatic int off_bits(input int words);
        return $clog2(words);
    endfunction

    function automatic int idx_bits(input int lines);
        return $clog2(lines);
    endfunction

    // Tag = everything above byte, word-offset and index fields.
    function automatic int tag_bits(input int lines, input int words);
        return 32 - 2 - $clog2(words) - $clog2(lines);
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] value);
        return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/mem_dcache_if.sv
// mem_dcache_if: one-word-per-beat request/acknowledge bus between the
// data cache and main memory.
//   master (cache) : drives mem_req, mem_we, mem_addr, mem_wdata;
//                    receives mem_ack, mem_rdata
//   slave (memory) : the mirror image
// A beat is offered with mem_req=1 and completes in the cycle mem_ack=1;
// for fill beats mem_rdata is valid in that same cycle.
interface mem_dcache_if;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_ack,
        output mem_rdata
    );

endinterface

// File: rtl/mem_dcache_store.sv
// dcache_store: line storage for the direct-mapped data cache.
//   clk, rst          : clock; rst clears every valid and dirty bit
//   rd_index          : line selected for the combinational read port
//   rd_valid/rd_dirty/rd_tag/rd_words : state and all words of that line
//   wr_en/wr_index/wr_offset/wr_data  : single-word data write (clock edge)
//   meta_we/meta_index/meta_dirty/meta_tag : marks a line valid and sets
//                       its dirty bit and tag (clock edge)
// Data lives in one bank per word position so a whole line can be read
// at once (the write-back path walks the words of the victim line).
module dcache_store #(
    parameter int LINES = 64,
    parameter int WORDS = 4,
    parameter int IDX_W = 6,
    parameter int OFF_W = 2,
    parameter int TAG_W = 22
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [IDX_W-1:0]            rd_index,
    output logic                        rd_valid,
    output logic                        rd_dirty,
    output logic [TAG_W-1:0]            rd_tag,
    output logic [WORDS-1:0][31:0]      rd_words,
    input  logic                        wr_en,
    input  logic [IDX_W-1:0]            wr_index,
    input  logic [OFF_W-1:0]            wr_offset,
    input  logic [31:0]                 wr_data,
    input  logic                        meta_we,
    input  logic [IDX_W-1:0]            meta_index,
    input  logic                        meta_dirty,
    input  logic [TAG_W-1:0]            meta_tag
);

    logic [LINES-1:0] valid_reg;
    logic [LINES-1:0] dirty_reg;
    logic [TAG_W-1:0] tag_mem [LINES];

    // Valid/dirty are flops so that reset can invalidate every line at once.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_reg <= '0;
            dirty_reg <= '0;
        end else if (meta_we) begin
            valid_reg[meta_index] <= 1'b1;
            dirty_reg[meta_index] <= meta_dirty;
        end
    end

    // Tags need no reset: a line is only trusted while its valid bit is set.
    always_ff @(posedge clk) begin
        if (meta_we) begin
            tag_mem[meta_index] <= meta_tag;
        end
    end

    assign rd_valid = valid_reg[rd_index];
    assign rd_dirty = dirty_reg[rd_index];
    assign rd_tag   = tag_mem[rd_index];

    genvar gi;
    generate
        for (gi = 0; gi < WORDS; gi++) begin : g_bank
            logic [31:0] bank_mem [LINES];

            always_ff @(posedge clk) begin
                if (wr_en && (wr_offset == OFF_W'(gi))) begin
                    bank_mem[wr_index] <= wr_data;
                end
            end

            assign rd_words[gi] = bank_mem[rd_index];
        end
    endgenerate

endmodule

// File: rtl/mem_dcache.sv
// mem_dcache: direct-mapped, write-back, write-allocate MEM-stage data cache.
//   clk, rst            : clock, synchronous active-high reset
//   cpu_req/cpu_we      : access valid / store (1) or load (0)
//   cpu_addr/cpu_wdata  : byte address (bits [1:0] ignored) / store data
//   cpu_rdata           : load data, valid when cpu_req && !cpu_stall
//   cpu_stall           : access not complete this cycle (pipeline freeze)
//   mem_bus             : beat bus to main memory (master side)
//   hit_cnt/miss_cnt    : saturating hit and miss counters since reset
// A miss is detected in IDLE, optionally writes back the dirty victim one
// word per beat, then fills the line one word per beat and returns to
// IDLE, where the still-held access replays and hits.
module mem_dcache
    import mem_dcache_pkg::*;
#(
    parameter int LINES = DEFAULT_LINES,
    parameter int WORDS = DEFAULT_WORDS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cpu_req,
    input  logic                cpu_we,
    input  logic [31:0]         cpu_addr,
    input  logic [31:0]         cpu_wdata,
    output logic [31:0]         cpu_rdata,
    output logic                cpu_stall,
    mem_dcache_if.master        mem_bus,
    output logic [31:0]         hit_cnt,
    output logic [31:0]         miss_cnt
);

    localparam int OFF_W = off_bits(WORDS);
    localparam int IDX_W = idx_bits(LINES);
    localparam int TAG_W = tag_bits(LINES, WORDS);
    localparam int OB    = 2 + OFF_W;
    localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(WORDS - 1);

    // Address split of the incoming CPU access.
    logic [OFF_W-1:0] cpu_off;
    logic [IDX_W-1:0] cpu_idx;
    logic [TAG_W-1:0] cpu_tag;
    logic [1:0]       unused_byte_bits;

    assign cpu_off          = cpu_addr[OB-1:2];
    assign cpu_idx          = cpu_addr[OB+IDX_W-1:OB];
    assign cpu_tag          = cpu_addr[31:OB+IDX_W];
    assign unused_byte_bits = cpu_addr[1:0];

    // Controller state.
    state_t           state_reg, state_next;
    logic [OFF_W-1:0] beat_reg, beat_next;
    logic [IDX_W-1:0] miss_idx_reg;
    logic [TAG_W-1:0] miss_tag_reg;
    logic [31:0]      hit_cnt_reg;
    logic [31:0]      miss_cnt_reg;

    // Storage ports.
    logic [IDX_W-1:0]       rd_index;
    logic                   rd_valid;
    logic                   rd_dirty;
    logic [TAG_W-1:0]       rd_tag;
    logic [WORDS-1:0][31:0] rd_words;
    logic                   wr_en;
    logic [IDX_W-1:0]       wr_index;
    logic [OFF_W-1:0]       wr_offset;
    logic [31:0]            wr_data;
    logic                   meta_we;
    logic [IDX_W-1:0]       meta_index;
    logic                   meta_dirty;
    logic [TAG_W-1:0]       meta_tag;

    logic hit;
    logic hit_evt;
    logic miss_evt;
    logic last_ack;

    // During a miss the store is addressed by the latched line, never by
    // cpu_addr, so the victim tag and words stay put for the whole burst.
    assign rd_index = (state_reg == ST_IDLE) ? cpu_idx : miss_idx_reg;
    assign hit      = cpu_req && rd_valid && (rd_tag == cpu_tag);
    assign last_ack = mem_bus.mem_ack && (beat_reg == LAST_BEAT);

    dcache_store #(
        .LINES (LINES),
        .WORDS (WORDS),
        .IDX_W (IDX_W),
        .OFF_W (OFF_W),
        .TAG_W (TAG_W)
    ) u_store (
        .clk        (clk),
        .rst        (rst),
        .rd_index   (rd_index),
        .rd_valid   (rd_valid),
        .rd_dirty   (rd_dirty),
        .rd_tag     (rd_tag),
        .rd_words   (rd_words),
        .wr_en      (wr_en),
        .wr_index   (wr_index),
        .wr_offset  (wr_offset),
        .wr_data    (wr_data),
        .meta_we    (meta_we),
        .meta_index (meta_index),
        .meta_dirty (meta_dirty),
        .meta_tag   (meta_tag)
    );

    // State register (plus the beat counter and the latched miss line).
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            beat_reg     <= '0;
            miss_idx_reg <= '0;
            miss_tag_reg <= '0;
        end else begin
            state_reg <= state_next;
            beat_reg  <= beat_next;
            if (miss_evt) begin
                miss_idx_reg <= cpu_idx;
                miss_tag_reg <= cpu_tag;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state_reg;
        beat_next  = beat_reg;
        case (state_reg)
            ST_IDLE: begin
                if (cpu_req && !hit) begin
                    state_next = (rd_valid && rd_dirty) ? ST_WB : ST_FILL;
                end
            end
            ST_WB: begin
                if (last_ack) begin
                    beat_next  = '0;
                    state_next = ST_FILL;
                end else if (mem_bus.mem_ack) begin
                    beat_next = beat_reg + OFF_W'(1);
                end
            end
            ST_FILL: begin
                if (last_ack) begin
                    beat_next  = '0;
                    state_next = ST_IDLE;
                end else if (mem_bus.mem_ack) begin
                    beat_next = beat_reg + OFF_W'(1);
                end
            end
            default: begin
                state_next = ST_IDLE;
                beat_next  = '0;
            end
        endcase
    end

    // Output logic: CPU side, memory bus and storage write ports.
    always_comb begin
        cpu_stall         = 1'b0;
        cpu_rdata         = MEM_WB_BUBBLE;
        mem_bus.mem_req   = 1'b0;
        mem_bus.mem_we    = 1'b0;
        mem_bus.mem_addr  = '0;
        mem_bus.mem_wdata = '0;
        wr_en             = 1'b0;
        wr_index          = cpu_idx;
        wr_offset         = cpu_off;
        wr_data           = cpu_wdata;
        meta_we           = 1'b0;
        meta_index        = cpu_idx;
        meta_dirty        = 1'b1;
        meta_tag          = cpu_tag;
        hit_evt           = 1'b0;
        miss_evt          = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (cpu_req) begin
                    if (hit) begin
                        hit_evt = 1'b1;
                        if (cpu_we) begin
                            // Store hit: word and dirty bit update at the edge.
                            wr_en   = 1'b1;
                            meta_we = 1'b1;
                        end else begin
                            cpu_rdata = rd_words[cpu_off];
                        end
                    end else begin
                        cpu_stall = 1'b1;
                        miss_evt  = 1'b1;
                    end
                end
            end
            ST_WB: begin
                cpu_stall         = 1'b1;
                mem_bus.mem_req   = 1'b1;
                mem_bus.mem_we    = 1'b1;
                mem_bus.mem_addr  = {rd_tag, miss_idx_reg, beat_reg, 2'b00};
                mem_bus.mem_wdata = rd_words[beat_reg];
            end
            ST_FILL: begin
                cpu_stall        = 1'b1;
                mem_bus.mem_req  = 1'b1;
                mem_bus.mem_addr = {miss_tag_reg, miss_idx_reg, beat_reg, 2'b00};
                if (mem_bus.mem_ack) begin
                    wr_en     = 1'b1;
                    wr_index  = miss_idx_reg;
                    wr_offset = beat_reg;
                    wr_data   = mem_bus.mem_rdata;
                end
                if (last_ack) begin
                    // Line becomes valid and clean with the final beat.
                    meta_we    = 1'b1;
                    meta_index = miss_idx_reg;
                    meta_dirty = 1'b0;
                    meta_tag   = miss_tag_reg;
                end
            end
            default: begin
                cpu_stall = 1'b0;
            end
        endcase

        // Reset wins over any write or count in the same cycle.
        if (rst) begin
            wr_en    = 1'b0;
            meta_we  = 1'b0;
            hit_evt  = 1'b0;
            miss_evt = 1'b0;
        end
    end

    // Counters: one miss per IDLE->WB/FILL transition, one hit per IDLE hit
    // (including the replay after a fill).
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt_reg  <= '0;
            miss_cnt_reg <= '0;
        end else begin
            if (hit_evt) begin
                hit_cnt_reg <= sat_inc(hit_cnt_reg);
            end
            if (miss_evt) begin
                miss_cnt_reg <= sat_inc(miss_cnt_reg);
            end
        end
    end

    assign hit_cnt  = hit_cnt_reg;
    assign miss_cnt = miss_cnt_reg;

endmodule

// File: tb/tb_mem_dcache.sv
// tb_mem_dcache: scoreboard bench for mem_dcache (LINES=64, WORDS=4).
// A behavioural cache model predicts, per CPU access, the memory beats and
// the load data; a monitor thread pops and compares them as the DUT
// presents beats (mem_req && mem_ack) and completes loads. A memory
// responder thread answers beats after a programmable wait and checks the
// beat signals stay stable while a beat is pending.
module tb_mem_dcache;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;

    mem_dcache_if mem_bus();

    mem_dcache dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_stall (cpu_stall),
        .mem_bus   (mem_bus),
        .hit_cnt   (hit_cnt),
        .miss_cnt  (miss_cnt)
    );

    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;
    int mem_delay  = 1;

    // Reference model: cache contents by line, plus the memory image the
    // model believes main memory holds.
    logic              m_valid [64];
    logic              m_dirty [64];
    logic [21:0]       m_tag   [64];
    logic [31:0]       m_data  [64][4];
    logic [31:0]       model_mem [logic [31:0]];
    int                m_hits;
    int                m_misses;
    beat_t             exp_beats [$];
    logic [31:0]       exp_loads [$];

    // Memory image seen by the responder (updated from real write-backs).
    logic [31:0]       phys_mem [logic [31:0]];

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] model_rd(input logic [31:0] a);
        if (model_mem.exists(a)) return model_mem[a];
        return init_word(a);
    endfunction

    function automatic logic [31:0] phys_rd(input logic [31:0] a);
        if (phys_mem.exists(a)) return phys_mem[a];
        return init_word(a);
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s got=%08h want=%08h", name, got, want);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 64; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
        end
        m_hits   = 0;
        m_misses = 0;
        exp_beats.delete();
        exp_loads.delete();
    endtask

    // Predict one access: on a miss, write back a dirty victim word by
    // word, then fetch the new line; the access itself then hits.
    task automatic model_access(input logic we, input logic [31:0] addr, input logic [31:0] data);
        int          idx;
        int          off;
        logic [21:0] tag;
        logic [31:0] a;
        beat_t       b;
        idx = int'(addr[9:4]);
        off = int'(addr[3:2]);
        tag = addr[31:10];
        if (!(m_valid[idx] && m_tag[idx] == tag)) begin
            m_misses++;
            if (m_valid[idx] && m_dirty[idx]) begin
                for (int w = 0; w < 4; w++) begin
                    a = {m_tag[idx], 6'(idx), 2'(w), 2'b00};
                    b.we = 1'b1; b.addr = a; b.data = m_data[idx][w];
                    exp_beats.push_back(b);
                    model_mem[a] = m_data[idx][w];
                end
            end
            for (int w = 0; w < 4; w++) begin
                a = {tag, 6'(idx), 2'(w), 2'b00};
                b.we = 1'b0; b.addr = a; b.data = 32'h0;
                exp_beats.push_back(b);
                m_data[idx][w] = model_rd(a);
            end
            m_valid[idx] = 1'b1;
            m_dirty[idx] = 1'b0;
            m_tag[idx]   = tag;
        end
        m_hits++;
        if (we) begin
            m_data[idx][off] = data;
            m_dirty[idx]     = 1'b1;
        end else begin
            exp_loads.push_back(m_data[idx][off]);
        end
    endtask

    task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] data,
                          output int stalls);
        bit done;
        model_access(we, addr, data);
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = data;
        stalls    = 0;
        done      = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (!cpu_stall) begin
                done = 1'b1;
            end else begin
                stalls++;
                if (stalls > 1000) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL access_timeout addr=%08h got stall after 1000 cycles want completion", addr);
                    done = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
        cpu_req = 1'b0;
        $display("access we=%0b addr=%08h wdata=%08h stalls=%0d hit_cnt=%0d miss_cnt=%0d",
                 we, addr, data, stalls, hit_cnt, miss_cnt);
    endtask

    task automatic check_counters(input string name);
        check({name, "_hit_cnt"},  hit_cnt,  32'(m_hits));
        check({name, "_miss_cnt"}, miss_cnt, 32'(m_misses));
    endtask

    task automatic do_reset();
        cpu_req = 1'b0;
        rst     = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          st;
        int          n;
        bit          found;
        logic [31:0] a;
        logic        held;
        logic        h_we;
        logic [31:0] h_addr;
        logic [31:0] h_wdata;
        int          cnt;
        beat_t       b;
        logic [31:0] want;

        rst       = 1'b1;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = 32'h0;
        cpu_wdata = 32'h0;
        mem_bus.mem_ack   = 1'b0;
        mem_bus.mem_rdata = 32'h0;
        model_reset();

        fork
            // Memory responder: acks each beat after mem_delay wait cycles.
            begin
                held = 1'b0;
                cnt  = 0;
                forever begin
                    @(posedge clk);
                    #1;
                    if (mem_bus.mem_ack) begin
                        mem_bus.mem_ack = 1'b0;
                        cnt  = 0;
                        held = 1'b0;
                    end
                    if (!mem_bus.mem_req) begin
                        cnt  = 0;
                        held = 1'b0;
                    end else begin
                        if (held) begin
                            vectors++;
                            if (mem_bus.mem_we !== h_we || mem_bus.mem_addr !== h_addr ||
                                mem_bus.mem_wdata !== h_wdata) begin
                                miscompares++;
                                $display("FAIL beat_stable got we=%0b addr=%08h wdata=%08h want we=%0b addr=%08h wdata=%08h",
                                         mem_bus.mem_we, mem_bus.mem_addr, mem_bus.mem_wdata,
                                         h_we, h_addr, h_wdata);
                            end
                        end else begin
                            held    = 1'b1;
                            h_we    = mem_bus.mem_we;
                            h_addr  = mem_bus.mem_addr;
                            h_wdata = mem_bus.mem_wdata;
                        end
                        if (cnt >= mem_delay) begin
                            mem_bus.mem_ack = 1'b1;
                            if (mem_bus.mem_we) phys_mem[mem_bus.mem_addr] = mem_bus.mem_wdata;
                            else mem_bus.mem_rdata = phys_rd(mem_bus.mem_addr);
                        end else begin
                            cnt++;
                        end
                    end
                end
            end
            // Monitor: compares completed beats and loads with the model.
            forever begin
                @(negedge clk);
                if (mem_bus.mem_req && mem_bus.mem_ack) begin
                    vectors++;
                    if (exp_beats.size() == 0) begin
                        miscompares++;
                        $display("FAIL beat_extra got we=%0b addr=%08h want no beat",
                                 mem_bus.mem_we, mem_bus.mem_addr);
                    end else begin
                        b = exp_beats.pop_front();
                        if (mem_bus.mem_we !== b.we || mem_bus.mem_addr !== b.addr ||
                            (b.we && mem_bus.mem_wdata !== b.data)) begin
                            miscompares++;
                            $display("FAIL beat got we=%0b addr=%08h wdata=%08h want we=%0b addr=%08h wdata=%08h",
                                     mem_bus.mem_we, mem_bus.mem_addr, mem_bus.mem_wdata,
                                     b.we, b.addr, b.data);
                        end
                    end
                end
                if (!rst && cpu_req && !cpu_stall && !cpu_we) begin
                    vectors++;
                    if (exp_loads.size() == 0) begin
                        miscompares++;
                        $display("FAIL load_extra got rdata=%08h want no load", cpu_rdata);
                    end else begin
                        want = exp_loads.pop_front();
                        if (cpu_rdata !== want) begin
                            miscompares++;
                            $display("FAIL load addr=%08h got rdata=%08h want %08h",
                                     cpu_addr, cpu_rdata, want);
                        end
                    end
                end
            end
        join_none

        // Reset state.
        do_reset();
        check("reset_mem_req",   32'(mem_bus.mem_req), 32'd0);
        check("reset_cpu_stall", 32'(cpu_stall), 32'd0);
        check("reset_cpu_rdata", cpu_rdata, 32'd0);
        check("reset_hit_cnt",   hit_cnt, 32'd0);
        check("reset_miss_cnt",  miss_cnt, 32'd0);

        // Cold miss: 1 detect cycle + 4 beats of 2 cycles.
        mem_delay = 1;
        access(1'b0, 32'h0000_0040, 32'h0, st);
        check("cold_stalls", 32'(st), 32'd9);
        check_counters("cold");

        // Store hit then load hit, no stall.
        access(1'b1, 32'h0000_0044, 32'hDEAD_BEEF, st);
        check("store_hit_stalls", 32'(st), 32'd0);
        access(1'b0, 32'h0000_0044, 32'h0, st);
        check("load_hit_stalls", 32'(st), 32'd0);

        // Dirty eviction: 1 + 8 beats of 2 cycles.
        access(1'b0, 32'h0000_1040, 32'h0, st);
        check("evict_stalls", 32'(st), 32'd17);
        check_counters("evict");

        // Slow memory: 3 wait cycles per beat, write-back plus fill.
        mem_delay = 3;
        access(1'b1, 32'h0000_1048, 32'h1234_5678, st);
        access(1'b0, 32'h0000_2040, 32'h0, st);
        check("slow_stalls", 32'(st), 32'd33);
        check_counters("slow");

        // Reset during the ack of fill beat 2.
        mem_delay = 1;
        model_access(1'b0, 32'h0000_3040, 32'h0);
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 32'h0000_3040;
        found    = 1'b0;
        n        = 0;
        while (!found && n < 200) begin
            @(negedge clk);
            n++;
            if (mem_bus.mem_req && mem_bus.mem_ack && !mem_bus.mem_we &&
                mem_bus.mem_addr == 32'h0000_3048) found = 1'b1;
        end
        check("rst_fill_beat2_seen", 32'(found), 32'd1);
        rst     = 1'b1;
        cpu_req = 1'b0;
        @(posedge clk);
        #1;
        check("rst_mid_mem_req",   32'(mem_bus.mem_req), 32'd0);
        check("rst_mid_cpu_stall", 32'(cpu_stall), 32'd0);
        check("rst_mid_hit_cnt",   hit_cnt, 32'd0);
        check("rst_mid_miss_cnt",  miss_cnt, 32'd0);
        rst = 1'b0;
        model_reset();
        $display("reset applied during fill beat 2");
        access(1'b0, 32'h0000_0040, 32'h0, st);
        check("rst_reload_stalls", 32'(st), 32'd9);
        check_counters("rst_reload");

        // Hit/miss mix: 100 sequential loads over 25 lines.
        do_reset();
        for (int i = 0; i < 100; i++) begin
            access(1'b0, 32'(i * 4), 32'h0, st);
        end
        check("mix_miss_cnt", miss_cnt, 32'd25);
        check("mix_hit_cnt",  hit_cnt, 32'd100);
        check_counters("mix");

        // Random loads/stores over a few conflicting lines, random waits.
        for (int i = 0; i < 300; i++) begin
            mem_delay = int'($urandom_range(0, 3));
            a = 32'($urandom_range(0, 3) << 10) | 32'($urandom_range(0, 7) << 4) |
                32'($urandom_range(0, 3) << 2);
            access(1'($urandom_range(0, 1)), a, $urandom, st);
        end
        check_counters("random");

        repeat (5) @(posedge clk);
        #1;
        check("left_beats", 32'(exp_beats.size()), 32'd0);
        check("left_loads", 32'(exp_loads.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
